// File: rtl/br_pkg.sv
// Shared branch-unit types: branch opcodes, condition codes and flag bit positions.
package br_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_JMP  = 2'b01,
    BR_COND = 2'b10,
    BR_JREG = 2'b11
  } br_op_e;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_MI = 3'd2,
    COND_PL = 3'd3,
    COND_CS = 3'd4,
    COND_CC = 3'd5,
    COND_VS = 3'd6,
    COND_LE = 3'd7
  } br_cond_e;

  // Bit positions inside the {V,C,N,Z} flag vector
  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: condition code + {V,C,N,Z} flags -> cond_true.
// Zero latency, no flow control.
module branch_cond_eval
  import br_pkg::*;
(
  input  logic [2:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_e'(cond))
      COND_EQ: cond_true =  flags[FLG_Z];
      COND_NE: cond_true = ~flags[FLG_Z];
      COND_MI: cond_true =  flags[FLG_N];
      COND_PL: cond_true = ~flags[FLG_N];
      COND_CS: cond_true =  flags[FLG_C];
      COND_CC: cond_true = ~flags[FLG_C];
      COND_VS: cond_true =  flags[FLG_V];
      COND_LE: cond_true =  flags[FLG_Z] | flags[FLG_N];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: flag register, same-cycle branch decision, registered front-end flush.
// Optional BR_STATS_EN adds resolved/taken branch counters (br_cnt, tkn_cnt).
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int                        ALU_SEL_W    = 4,
  parameter logic [2**ALU_SEL_W-1:0]   FLAG_OP_MASK = 16'h003E,
  parameter int                        FLUSH_STAGES = 2,
  parameter int                        CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [ALU_SEL_W-1:0] ex_alu_sel,
  input  logic                 alu_z,
  input  logic                 alu_n,
  input  logic                 alu_c,
  input  logic                 alu_v,
  input  logic [1:0]           ex_br_op,
  input  logic [2:0]           ex_cond,
  output logic                 br_taken,
  output logic                 br_sel,
  output logic                 br_type_sel,
  output logic                 flush,
  output logic [FLAG_W-1:0]    flags_q
`ifdef BR_STATS_EN
  ,
  output logic [CNT_W-1:0]     br_cnt,
  output logic [CNT_W-1:0]     tkn_cnt
`endif
);

  if (FLUSH_STAGES < 1 || FLUSH_STAGES > 7) begin : g_bad_flush
    $fatal(1, "branch_resolve_unit: FLUSH_STAGES must be in 1..7");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $fatal(1, "branch_resolve_unit: CNT_W must be at least 1");
  end

  logic [2:0]        r_flush_cnt;
  logic [FLAG_W-1:0] r_flags;
  logic              w_live;
  logic              w_cond_true;
  logic              w_flag_we;

  assign flush     = (r_flush_cnt != 3'd0);
  assign flags_q   = r_flags;
  // A slot sitting in EX while flush is high is squashed: it neither writes flags nor branches.
  assign w_live    = ex_valid & ~flush & ~rst;
  assign w_flag_we = w_live & FLAG_OP_MASK[ex_alu_sel];

  branch_cond_eval u_cond (
    .cond      (ex_cond),
    .flags     (r_flags),
    .cond_true (w_cond_true)
  );

  always_comb begin
    br_taken    = 1'b0;
    br_sel      = 1'b0;
    br_type_sel = 1'b0;
    if (w_live) begin
      case (br_op_e'(ex_br_op))
        BR_JMP: begin
          br_taken = 1'b1;
          br_sel   = 1'b1;
        end
        BR_JREG: begin
          br_taken    = 1'b1;
          br_sel      = 1'b1;
          br_type_sel = 1'b1;
        end
        BR_COND: begin
          br_taken = w_cond_true;
          br_sel   = w_cond_true;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= '0;
      r_flush_cnt <= 3'd0;
    end else begin
      if (w_flag_we)
        r_flags <= {alu_v, alu_c, alu_n, alu_z};
      // br_taken already implies live, so no retrigger can happen mid-flush
      if (br_taken)
        r_flush_cnt <= 3'(FLUSH_STAGES);
      else if (flush)
        r_flush_cnt <= r_flush_cnt - 3'd1;
    end
  end

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_tkn_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_tkn_cnt <= '0;
    end else begin
      if (w_live && (ex_br_op != BR_NONE))
        r_br_cnt <= r_br_cnt + 1'b1;
      if (br_taken)
        r_tkn_cnt <= r_tkn_cnt + 1'b1;
    end
  end

  assign br_cnt  = r_br_cnt;
  assign tkn_cnt = r_tkn_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit with a queue-based scoreboard.
module tb_branch_resolve_unit;

  localparam int          SEL_W = 4;
  localparam logic [15:0] MASK  = 16'h003E;
  localparam int          FS    = 2;
  localparam int          CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [SEL_W-1:0] ex_alu_sel;
  logic             alu_z, alu_n, alu_c, alu_v;
  logic [1:0]       ex_br_op;
  logic [2:0]       ex_cond;
  logic             br_taken, br_sel, br_type_sel, flush;
  logic [3:0]       flags_q;
`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_cnt, tkn_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .ALU_SEL_W    (SEL_W),
    .FLAG_OP_MASK (MASK),
    .FLUSH_STAGES (FS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_sel  (ex_alu_sel),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .alu_c       (alu_c),
    .alu_v       (alu_v),
    .ex_br_op    (ex_br_op),
    .ex_cond     (ex_cond),
    .br_taken    (br_taken),
    .br_sel      (br_sel),
    .br_type_sel (br_type_sel),
    .flush       (flush),
    .flags_q     (flags_q)
`ifdef BR_STATS_EN
    ,
    .br_cnt      (br_cnt),
    .tkn_cnt     (tkn_cnt)
`endif
  );

  typedef struct {
    logic       taken;
    logic       sel;
    logic       typ;
    logic       flush;
    logic [3:0] flags;
    int         br;
    int         tk;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: flags, last cycle index that still shows flush, and stats counts
  bit [3:0] m_flags;
  int       m_flush_until;
  int       m_br, m_tk;
  int       cyc;

  function automatic bit cond_true(int c, bit [3:0] f);
    bit z, n, cy, v;
    {v, cy, n, z} = f;
    case (c)
      0: return z;
      1: return !z;
      2: return n;
      3: return !n;
      4: return cy;
      5: return !cy;
      6: return v;
      default: return z | n;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags       = 4'b0000;
    m_flush_until = -1;
    m_br          = 0;
    m_tk          = 0;
  endtask

  task automatic step(bit r, bit vld, int sel, bit [3:0] vcnz, int op, int cond);
    exp_t e;
    bit   fl, live, tk;
    @(posedge clk);
    #1;
    rst        = r;
    ex_valid   = vld;
    ex_alu_sel = sel[SEL_W-1:0];
    {alu_v, alu_c, alu_n, alu_z} = vcnz;
    ex_br_op   = op[1:0];
    ex_cond    = cond[2:0];
    fl   = (cyc <= m_flush_until);
    live = vld && !fl && !r;
    tk   = live && (op == 1 || op == 3 || (op == 2 && cond_true(cond, m_flags)));
    e.taken = tk;
    e.sel   = tk;
    e.typ   = live && (op == 3);
    e.flush = fl;
    e.flags = m_flags;
    e.br    = m_br;
    e.tk    = m_tk;
    q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      if (live && MASK[sel]) m_flags = vcnz;
      if (tk) m_flush_until = cyc + FS;
      if (live && op != 0) m_br = (m_br + 1) % (1 << CNT_W);
      if (tk) m_tk = (m_tk + 1) % (1 << CNT_W);
    end
    cyc++;
  endtask

  // Monitor: one expected entry per cycle, checked mid-cycle after inputs settle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("br_taken", 32'(br_taken), 32'(e.taken));
        chk("br_sel", 32'(br_sel), 32'(e.sel));
        chk("br_type_sel", 32'(br_type_sel), 32'(e.typ));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("flags_q", 32'(flags_q), 32'(e.flags));
`ifdef BR_STATS_EN
        chk("br_cnt", 32'(br_cnt), 32'(e.br));
        chk("tkn_cnt", 32'(tkn_cnt), 32'(e.tk));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_alu_sel = '0;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    ex_br_op = 2'b00; ex_cond = 3'd0;
    cyc = 0;
    @(posedge clk);
    model_reset();

    // Reset held with a live-looking jump present
    step(1, 1, 0, 4'b0000, 1, 0);
    step(1, 1, 0, 4'b0000, 1, 0);
    // Flag-setting SUB with Z, then EQ taken; NE after the flush drains
    step(0, 1, 1, 4'b0001, 0, 0);
    step(0, 1, 0, 4'b0000, 2, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0000, 2, 1);
    // Register jump; branches during flush are ignored, accepted at t+3
    step(0, 1, 0, 4'b0000, 3, 0);
    step(0, 1, 0, 4'b0000, 1, 0);
    step(0, 1, 0, 4'b0000, 3, 0);
    step(0, 1, 0, 4'b0000, 1, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    // Flag op squashed by flush; non-flag op live leaves flags alone
    step(0, 1, 0, 4'b0000, 3, 0);
    step(0, 1, 2, 4'b0010, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 6, 4'b1111, 0, 0);
    // Reset in the middle of a flush, then a fresh full-length flush
    step(0, 1, 0, 4'b0000, 1, 0);
    step(1, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0000, 1, 0);
    step(0, 1, 0, 4'b0000, 1, 0);
    step(0, 1, 0, 4'b0000, 1, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    // Counter wrap: 17 taken jumps after a reset, then 3 not-taken conds
    step(1, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 4'b0000, 1, 0);
      step(0, 1, 0, 4'b0000, 1, 0);
      step(0, 1, 0, 4'b0000, 1, 0);
    end
    step(0, 1, 1, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b0000, 2, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
